// File: rtl/uart_tx_serializer.sv
// Fabric-side UART transmitter: valid/ready byte input, one-entry holding register, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1 framing).
module uart_tx_serializer #(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_tx_serializer: CLKS_PER_BIT must be at least 4");
    end

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       shift_q;
    logic [7:0]       shift_nxt;
    logic             hold_valid;
    logic             hold_valid_nxt;
    logic [7:0]       hold_data;
    logic [7:0]       hold_data_nxt;
    logic             txd_nxt;
    logic             done_nxt;
    logic             accept;
    logic             load;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_q;
    logic             par_nxt;
`endif

    assign accept  = tx_valid & tx_ready;
    assign bit_end = (baud_cnt == CNT_LAST);
    assign tx_busy = (state != ST_IDLE) | hold_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // uart_txd and frame_done are registered from the current state, so they
    // trail the FSM by one cycle and never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            tx_ready   <= 1'b1;
            uart_txd   <= 1'b1;
            frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            baud_cnt   <= cnt_nxt;
            bit_idx    <= idx_nxt;
            shift_q    <= shift_nxt;
            hold_valid <= hold_valid_nxt;
            hold_data  <= hold_data_nxt;
            tx_ready   <= ~hold_valid_nxt;
            uart_txd   <= txd_nxt;
            frame_done <= done_nxt;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = baud_cnt;
        idx_nxt        = bit_idx;
        shift_nxt      = shift_q;
        hold_valid_nxt = hold_valid;
        hold_data_nxt  = hold_data;
        txd_nxt        = 1'b1;
        done_nxt       = 1'b0;
        load           = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt        = par_q;
`endif

        case (state)
            ST_IDLE: begin
                txd_nxt = 1'b1;
                if (hold_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_START;
                    cnt_nxt   = '0;
                end
            end

            ST_START: begin
                txd_nxt = 1'b0;
                if (bit_end) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end

            ST_DATA: begin
                txd_nxt = shift_q[0];
                if (bit_end) begin
                    cnt_nxt   = '0;
                    shift_nxt = {1'b0, shift_q[7:1]};
                    if (bit_idx == 3'd7) begin
                        idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                txd_nxt = par_q;
                if (bit_end) begin
                    state_nxt = ST_STOP;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
`endif

            ST_STOP: begin
                txd_nxt = 1'b1;
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (bit_idx == STOP_LAST) begin
                        done_nxt = 1'b1;
                        idx_nxt  = '0;
                        // A queued byte starts its start bit straight after the stop bit.
                        if (hold_valid) begin
                            load      = 1'b1;
                            state_nxt = ST_START;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase

        if (load) begin
            shift_nxt      = hold_data;
            hold_valid_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_nxt        = ^hold_data;
`endif
        end

        // Accept after transfer so a same-cycle handshake refills the holding register.
        if (accept) begin
            hold_valid_nxt = 1'b1;
            hold_data_nxt  = tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer at default baud settings.
// A second instance with STOP_BITS=2 covers the two-stop-bit frame.
module tb_uart_tx_serializer;

    localparam int CPB = 868;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB1 = 10 + PAR;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic       frame_done;
    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       uart_txd2;
    logic       tx_busy2;
    logic       frame_done2;

    always #5 clk = ~clk;

    uart_tx_serializer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    uart_tx_serializer #(.STOP_BITS(2)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
        .uart_txd   (uart_txd2),
        .tx_busy    (tx_busy2),
        .frame_done (frame_done2)
    );

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   sel = 1'b0;
    logic mtxd;
    logic mdone;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        mtxd  = sel ? uart_txd2 : uart_txd;
        mdone = sel ? frame_done2 : frame_done;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input string tag, input int limit);
        int n;
        n = 0;
        while (mtxd !== 1'b0 && n < limit) begin
            tick(1);
            n++;
        end
        check_eq({tag, "_start_seen"}, mtxd, 0);
    endtask

    // Called on the first cycle of the start bit; returns on the cycle after the frame.
    task automatic chk_frame(input string tag, input logic [7:0] b, input int nstop);
        logic [15:0] bits;
        int nb;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
        nb = 9;
`ifdef UART_TX_PARITY_EN
        bits[nb] = ^b;
        nb++;
`endif
        for (int s = 0; s < nstop; s++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        for (int i = 0; i < nb; i++) begin
            check_eq($sformatf("%s_bit%0d_first", tag, i), mtxd, bits[i]);
            tick(CPB - 1);
            check_eq($sformatf("%s_bit%0d_last", tag, i), mtxd, bits[i]);
            check_eq($sformatf("%s_bit%0d_done", tag, i), mdone, (i == nb - 1));
            tick(1);
        end
        check_eq({tag, "_done_clear"}, mdone, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_data2  = 8'h00;
        tx_valid2 = 1'b0;
        tick(3);
        check_eq("rst_txd", uart_txd, 1);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_txd2", uart_txd2, 1);
        reset_n = 1'b1;
        tick(3);
        check_eq("idle_txd", uart_txd, 1);
        check_eq("idle_ready", tx_ready, 1);

        // single byte 0x55, exact latency
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        check_eq("t1_ready_after_accept", tx_ready, 0);
        check_eq("t1_busy_after_accept", tx_busy, 1);
        check_eq("t1_txd_cycle1", uart_txd, 1);
        tick(1);
        check_eq("t1_ready_after_load", tx_ready, 1);
        check_eq("t1_txd_before_start", uart_txd, 1);
        tick(1);
        chk_frame("t1", 8'h55, 1);
        check_eq("t1_idle_txd", uart_txd, 1);
        check_eq("t1_idle_busy", tx_busy, 0);
        tick(5);

        // back-to-back 0xA3 then 0x0F, second offered mid-DATA
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        wait_start("t2", 10);
        fork
            begin : t2_line
                chk_frame("t2a", 8'hA3, 1);
                chk_frame("t2b", 8'h0F, 1);
                check_eq("t2_idle_after", uart_txd, 1);
            end
            begin : t2_prod
                int s0;
                int n;
                s0 = cyc;
                n  = 0;
                tick(2000);
                check_eq("t2_ready_in_data", tx_ready, 1);
                tx_data  = 8'h0F;
                tx_valid = 1'b1;
                tick(1);
                tx_valid = 1'b0;
                tx_data  = 8'hFF;
                check_eq("t2_ready_held", tx_ready, 0);
                while (tx_ready !== 1'b1 && n < 20000) begin
                    tick(1);
                    n++;
                end
                check_eq("t2_ready_rise_cycle", cyc - s0, NB1 * CPB - 1);
            end
        join
        tick(5);

        // backpressure: 0x01, 0x02, 0x03 with tx_valid held
        fork
            begin : t3_line
                wait_start("t3", 10);
                chk_frame("t3a", 8'h01, 1);
                chk_frame("t3b", 8'h02, 1);
                chk_frame("t3c", 8'h03, 1);
                check_eq("t3_idle_txd", uart_txd, 1);
                check_eq("t3_idle_busy", tx_busy, 0);
            end
            begin : t3_prod
                int s0;
                int n;
                tx_data  = 8'h01;
                tx_valid = 1'b1;
                tick(1);
                tx_data = 8'h02;
                n = 0;
                while (tx_ready !== 1'b1 && n < 100) begin
                    tick(1);
                    n++;
                end
                tick(1);
                tx_data = 8'h03;
                check_eq("t3_third_stalled", tx_ready, 0);
                s0 = cyc;
                n  = 0;
                while (tx_ready !== 1'b1 && n < 20000) begin
                    tick(1);
                    n++;
                end
                check_eq("t3_stall_cycles", cyc - s0, NB1 * CPB - 1);
                tick(1);
                tx_valid = 1'b0;
            end
        join
        tick(5);

        // reset mid-DATA of 0xFF with 0x5A held
        begin : t4
            int n;
            int lows;
            tx_data  = 8'hFF;
            tx_valid = 1'b1;
            tick(1);
            tx_data = 8'h5A;
            n = 0;
            while (tx_ready !== 1'b1 && n < 100) begin
                tick(1);
                n++;
            end
            tick(1);
            tx_valid = 1'b0;
            wait_start("t4", 10);
            tick(CPB * 3);
            check_eq("t4_busy_before", tx_busy, 1);
            check_eq("t4_ready_before", tx_ready, 0);
            #2;
            reset_n = 1'b0;
            #1;
            check_eq("t4_txd_async", uart_txd, 1);
            check_eq("t4_ready_async", tx_ready, 1);
            check_eq("t4_busy_async", tx_busy, 0);
            tick(2);
            reset_n = 1'b1;
            tick(1);
            check_eq("t4_busy_release", tx_busy, 0);
            check_eq("t4_ready_release", tx_ready, 1);
            lows = 0;
            repeat (3 * CPB) begin
                tick(1);
                if (uart_txd !== 1'b1) lows++;
            end
            check_eq("t4_no_residual", lows, 0);

            // reset during a start bit must raise the line at once
            tx_data  = 8'h00;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            wait_start("t4b", 10);
            tick(100);
            #2;
            reset_n = 1'b0;
            #1;
            check_eq("t4b_txd_async", uart_txd, 1);
            tick(2);
            reset_n = 1'b1;
            tick(2);

            tx_data  = 8'hC3;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            tick(1);
            check_eq("t4c_txd_before_start", uart_txd, 1);
            tick(1);
            chk_frame("t4c", 8'hC3, 1);
            check_eq("t4c_idle_busy", tx_busy, 0);
        end
        tick(5);

        // two stop bits, byte 0x80
        sel       = 1'b1;
        tx_data2  = 8'h80;
        tx_valid2 = 1'b1;
        tick(1);
        tx_valid2 = 1'b0;
        wait_start("t5", 10);
        chk_frame("t5", 8'h80, 2);
        check_eq("t5_idle_txd", uart_txd2, 1);
        check_eq("t5_idle_busy", tx_busy2, 0);
        sel = 1'b0;
        tick(5);

`ifdef UART_TX_PARITY_EN
        // even parity: 0x07 -> 1, 0x03 -> 0
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        wait_start("t6a", 10);
        tick(9 * CPB);
        check_eq("t6a_parity", uart_txd, 1);
        tick(4 * CPB);
        tx_data  = 8'h03;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        wait_start("t6b", 10);
        tick(9 * CPB);
        check_eq("t6b_parity", uart_txd, 0);
        tick(3 * CPB);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
